kronos_mem_arbiter: RTL and testbench

Shares a single memory port between the Kronos instruction-fetch stage and the load/store unit. The block holds one granted transaction on the memory port until it is acknowledged or times out. It routes the response back to the owning requester. Arbitration is fixed-priority or round-robin, and a per-transaction watchdog reports unanswered requests as bus errors. It sits between the core's `instr_*` / `data_*` interfaces and the system memory bus.

---
 rtl/kronos_mem_arbiter.sv | 119 +++++++++++
 tb/tb_kronos_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with
// fixed-priority or round-robin arbitration and a per-transaction watchdog.
`timescale 1ns/1ps
module kronos_mem_arbiter #(
  parameter bit          FAIR    = 1'b1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_ack,
  output logic        instr_err,
  input  logic [31:0] data_addr,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_mask,
  input  logic [31:0] data_wr_data,
  output logic [31:0] data_rd_data,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ack
);

  localparam int unsigned CNT_W = (TIMEOUT != 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          WD_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

  state_t           state, state_nxt;
  state_t           last_grant;
  logic [CNT_W-1:0] wd_cnt;
  logic             expire_c, done_c, grant_instr_c, grant_data_c;

  // Read data is shared; only the owner's ack qualifies it.
  assign instr_data   = mem_rd_data;
  assign data_rd_data = mem_rd_data;

  always_ff @(posedge clk) begin
    if (!rstz) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    grant_instr_c = 1'b0;
    grant_data_c  = 1'b0;
    instr_ack     = 1'b0;
    data_ack      = 1'b0;
    instr_err     = 1'b0;
    data_err      = 1'b0;
    // An ack in the last watchdog cycle takes precedence over the error.
    expire_c      = WD_EN && (state != IDLE) && !mem_ack && (wd_cnt == WD_LAST);
    done_c        = (state != IDLE) && (mem_ack || expire_c);
    unique case (state)
      IDLE: begin
        if (data_req && (!instr_req || !FAIR || (last_grant == INSTR))) begin
          grant_data_c = 1'b1;
          state_nxt    = DATA;
        end else if (instr_req) begin
          grant_instr_c = 1'b1;
          state_nxt     = INSTR;
        end
      end
      INSTR: begin
        instr_ack = mem_ack;
        instr_err = expire_c;
        if (done_c) state_nxt = IDLE;
      end
      DATA: begin
        data_ack = mem_ack;
        data_err = expire_c;
        if (done_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory payload is captured only at grant and held while busy.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_mask    <= '0;
      mem_wr_data <= '0;
      last_grant  <= INSTR;
      wd_cnt      <= '0;
    end else if (grant_instr_c) begin
      mem_req    <= 1'b1;
      mem_addr   <= instr_addr;
      mem_we     <= 1'b0;
      mem_mask   <= 4'hF;
      last_grant <= INSTR;
      wd_cnt     <= '0;
    end else if (grant_data_c) begin
      mem_req     <= 1'b1;
      mem_addr    <= data_addr;
      mem_we      <= data_wr;
      mem_mask    <= data_mask;
      mem_wr_data <= data_wr_data;
      last_grant  <= DATA;
      wd_cnt      <= '0;
    end else if (done_c) begin
      mem_req <= 1'b0;
    end else if (state != IDLE) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Scoreboard bench for kronos_mem_arbiter: instance 0 is round-robin, instance 1
// is data-priority, both with a 4-cycle watchdog.
`timescale 1ns/1ps
module tb_kronos_mem_arbiter;

  localparam int K_GRANT = 0, K_DROP = 1, K_IACK = 2, K_DACK = 3,
                 K_IERR = 4, K_DERR = 5, K_SNAP = 6;

  typedef struct {
    int          d;
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic        we;
    logic [3:0]  m;
    logic [31:0] w;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rstz [2];
  logic [31:0] instr_addr [2];
  logic        instr_req [2];
  logic [31:0] instr_data [2];
  logic        instr_ack [2];
  logic        instr_err [2];
  logic [31:0] data_addr [2];
  logic        data_req [2];
  logic        data_wr [2];
  logic [3:0]  data_mask [2];
  logic [31:0] data_wr_data [2];
  logic [31:0] data_rd_data [2];
  logic        data_ack [2];
  logic        data_err [2];
  logic [31:0] mem_addr [2];
  logic        mem_req [2];
  logic        mem_we [2];
  logic [3:0]  mem_mask [2];
  logic [31:0] mem_wr_data [2];
  logic [31:0] mem_rd_data [2];
  logic        mem_ack [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    kronos_mem_arbiter #(.FAIR((g == 0) ? 1'b1 : 1'b0), .TIMEOUT(4)) u_dut (
      .clk(clk), .rstz(rstz[g]),
      .instr_addr(instr_addr[g]), .instr_req(instr_req[g]), .instr_data(instr_data[g]),
      .instr_ack(instr_ack[g]), .instr_err(instr_err[g]),
      .data_addr(data_addr[g]), .data_req(data_req[g]), .data_wr(data_wr[g]),
      .data_mask(data_mask[g]), .data_wr_data(data_wr_data[g]),
      .data_rd_data(data_rd_data[g]), .data_ack(data_ack[g]), .data_err(data_err[g]),
      .mem_addr(mem_addr[g]), .mem_req(mem_req[g]), .mem_we(mem_we[g]),
      .mem_mask(mem_mask[g]), .mem_wr_data(mem_wr_data[g]),
      .mem_rd_data(mem_rd_data[g]), .mem_ack(mem_ack[g])
    );
  end

  // Stimulus configuration, written by the main sequence only.
  logic        rst_cfg [2]    = '{1'b0, 1'b0};
  logic        spur_cfg [2]   = '{1'b0, 1'b0};
  int          lat_cfg [2]    = '{-1, -1};
  int          i_goal [2]     = '{0, 0};
  int          d_goal [2]     = '{0, 0};
  logic [31:0] i_addr_cfg [2] = '{32'h0, 32'h0};
  logic [31:0] d_addr_cfg [2] = '{32'h0, 32'h0};
  logic        d_wr_cfg [2]   = '{1'b0, 1'b0};
  logic [3:0]  d_mask_cfg [2] = '{4'h0, 4'h0};
  logic [31:0] d_wd_cfg [2]   = '{32'h0, 32'h0};
  logic [31:0] rdata_cfg [2]  = '{32'h0, 32'h0};
  logic        fin            = 1'b0;

  // Completion counts, written by the monitor only.
  int acks_i [2] = '{0, 0};
  int acks_d [2] = '{0, 0};

  int   total = 0;
  int   bad   = 0;
  exp_t q [$];
  exp_t hold [2];
  logic prev_req [2] = '{1'b0, 1'b0};
  int   busy_cnt [2] = '{0, 0};

  function automatic string kname(input int k);
    case (k)
      K_GRANT: return "grant";
      K_DROP:  return "drop";
      K_IACK:  return "iack";
      K_DACK:  return "dack";
      K_IERR:  return "ierr";
      K_DERR:  return "derr";
      default: return "snap";
    endcase
  endfunction

  // Requesters hold until their completion count is reached; memory acks lat cycles after mem_req.
  initial begin
    for (int d = 0; d < 2; d++) begin
      rstz[d] = 1'b0; instr_req[d] = 1'b0; instr_addr[d] = '0;
      data_req[d] = 1'b0; data_addr[d] = '0; data_wr[d] = 1'b0;
      data_mask[d] = '0; data_wr_data[d] = '0; mem_ack[d] = 1'b0; mem_rd_data[d] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        rstz[d]         = rst_cfg[d];
        instr_req[d]    = (acks_i[d] < i_goal[d]);
        instr_addr[d]   = i_addr_cfg[d];
        data_req[d]     = (acks_d[d] < d_goal[d]);
        data_addr[d]    = d_addr_cfg[d];
        data_wr[d]      = d_wr_cfg[d];
        data_mask[d]    = d_mask_cfg[d];
        data_wr_data[d] = d_wd_cfg[d];
        busy_cnt[d]     = mem_req[d] ? busy_cnt[d] + 1 : 0;
        mem_ack[d]      = spur_cfg[d] ||
                          ((lat_cfg[d] >= 0) && mem_req[d] && (busy_cnt[d] == lat_cfg[d] + 1));
        mem_rd_data[d]  = rdata_cfg[d];
      end
    end
  end

  task automatic ev(input int d, input int kind, input int c, input logic [31:0] a,
                    input logic we, input logic [3:0] m, input logic [31:0] w);
    exp_t e;
    e.d = d; e.kind = kind; e.cyc = c; e.a = a; e.we = we; e.m = m; e.w = w;
    q.push_back(e);
  endtask

  // One transaction: grant at g, completion at c, mem_req falls at c+1 with payload held.
  task automatic txn(input int d, input int g, input int c, input int ck, input logic [31:0] rd,
                     input logic [31:0] a, input logic we, input logic [3:0] m, input logic [31:0] w);
    ev(d, K_GRANT, g, a, we, m, w);
    ev(d, ck, c, rd, 1'b0, 4'h0, 32'h0);
    ev(d, K_DROP, c + 1, a, we, m, w);
  endtask

  task automatic observe(input int d, input int kind, input logic [31:0] a, input logic we,
                         input logic [3:0] m, input logic [31:0] w);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: dut%0d %s at cycle %0d a=%h, want none", d, kname(kind), cyc, a);
      return;
    end
    e = q.pop_front();
    if (e.d != d || e.kind != kind || e.cyc != cyc || e.a !== a || e.we !== we ||
        e.m !== m || e.w !== w) begin
      bad++;
      $display("FAIL event: got dut%0d %s@%0d a=%h we=%b m=%h w=%h, want dut%0d %s@%0d a=%h we=%b m=%h w=%h",
               d, kname(kind), cyc, a, we, m, w, e.d, kname(e.kind), e.cyc, e.a, e.we, e.m, e.w);
    end
    if (kind == K_GRANT) hold[d] = e;
  endtask

  // Monitor: samples on the falling edge and retires scoreboard entries.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        while (q.size() > 0 && q[0].kind == K_SNAP && q[0].d == d && q[0].cyc == cyc) begin
          e = q.pop_front();
          total++;
          if (mem_req[d] !== 1'b0 || mem_addr[d] !== e.a || mem_we[d] !== e.we ||
              mem_mask[d] !== e.m || mem_wr_data[d] !== e.w ||
              {instr_ack[d], data_ack[d], instr_err[d], data_err[d]} !== 4'b0000) begin
            bad++;
            $display("FAIL snapshot dut%0d@%0d: got req=%b a=%h we=%b m=%h w=%h ack/err=%b%b%b%b, want req=0 a=%h we=%b m=%h w=%h ack/err=0000",
                     d, cyc, mem_req[d], mem_addr[d], mem_we[d], mem_mask[d], mem_wr_data[d],
                     instr_ack[d], data_ack[d], instr_err[d], data_err[d], e.a, e.we, e.m, e.w);
          end
        end
        if (mem_req[d] && prev_req[d]) begin
          total++;
          if (mem_addr[d] !== hold[d].a || mem_we[d] !== hold[d].we ||
              mem_mask[d] !== hold[d].m || mem_wr_data[d] !== hold[d].w) begin
            bad++;
            $display("FAIL hold dut%0d@%0d: got a=%h we=%b m=%h w=%h, want a=%h we=%b m=%h w=%h",
                     d, cyc, mem_addr[d], mem_we[d], mem_mask[d], mem_wr_data[d],
                     hold[d].a, hold[d].we, hold[d].m, hold[d].w);
          end
        end
        if (mem_req[d] && !prev_req[d])
          observe(d, K_GRANT, mem_addr[d], mem_we[d], mem_mask[d], mem_wr_data[d]);
        if (!mem_req[d] && prev_req[d])
          observe(d, K_DROP, mem_addr[d], mem_we[d], mem_mask[d], mem_wr_data[d]);
        if (instr_ack[d]) observe(d, K_IACK, instr_data[d], 1'b0, 4'h0, 32'h0);
        if (data_ack[d])  observe(d, K_DACK, data_rd_data[d], 1'b0, 4'h0, 32'h0);
        if (instr_err[d]) observe(d, K_IERR, 32'h0, 1'b0, 4'h0, 32'h0);
        if (data_err[d])  observe(d, K_DERR, 32'h0, 1'b0, 4'h0, 32'h0);
        prev_req[d] = mem_req[d];
        if (instr_ack[d] || instr_err[d]) acks_i[d]++;
        if (data_ack[d] || data_err[d])   acks_d[d]++;
      end
      if (fin || cyc > 3000) begin
        total++;
        if (q.size() != 0 || !fin) begin
          bad++;
          $display("FAIL drain: %0d expected events left (finished=%b), want 0", q.size(), fin);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int r;
    repeat (2) @(negedge clk);
    ev(0, K_SNAP, cyc + 1, 32'h0, 1'b0, 4'h0, 32'h0);
    ev(1, K_SNAP, cyc + 1, 32'h0, 1'b0, 4'h0, 32'h0);
    wait_to(cyc + 1);
    rst_cfg[0] = 1'b1; rst_cfg[1] = 1'b1;
    repeat (2) @(negedge clk);

    // Contention, round-robin: D, I, D, I.
    i_addr_cfg[0] = 32'h300; d_addr_cfg[0] = 32'h400; d_wr_cfg[0] = 1'b0;
    d_mask_cfg[0] = 4'h5; d_wd_cfg[0] = 32'h55; lat_cfg[0] = 1; rdata_cfg[0] = 32'h0BADF00D;
    r = cyc + 1;
    i_goal[0] = acks_i[0] + 2; d_goal[0] = acks_d[0] + 2;
    txn(0, r + 1,  r + 2,  K_DACK, 32'h0BADF00D, 32'h400, 1'b0, 4'h5, 32'h55);
    txn(0, r + 4,  r + 5,  K_IACK, 32'h0BADF00D, 32'h300, 1'b0, 4'hF, 32'h55);
    txn(0, r + 7,  r + 8,  K_DACK, 32'h0BADF00D, 32'h400, 1'b0, 4'h5, 32'h55);
    txn(0, r + 10, r + 11, K_IACK, 32'h0BADF00D, 32'h300, 1'b0, 4'hF, 32'h55);
    wait_to(r + 15);

    // Same contention, data priority: D, D, I, I.
    i_addr_cfg[1] = 32'h300; d_addr_cfg[1] = 32'h400; d_wr_cfg[1] = 1'b0;
    d_mask_cfg[1] = 4'h5; d_wd_cfg[1] = 32'h55; lat_cfg[1] = 1; rdata_cfg[1] = 32'h0BADF00D;
    r = cyc + 1;
    i_goal[1] = acks_i[1] + 2; d_goal[1] = acks_d[1] + 2;
    txn(1, r + 1,  r + 2,  K_DACK, 32'h0BADF00D, 32'h400, 1'b0, 4'h5, 32'h55);
    txn(1, r + 4,  r + 5,  K_DACK, 32'h0BADF00D, 32'h400, 1'b0, 4'h5, 32'h55);
    txn(1, r + 7,  r + 8,  K_IACK, 32'h0BADF00D, 32'h300, 1'b0, 4'hF, 32'h55);
    txn(1, r + 10, r + 11, K_IACK, 32'h0BADF00D, 32'h300, 1'b0, 4'hF, 32'h55);
    wait_to(r + 15);

    // Single fetch, memory acks two cycles after mem_req.
    i_addr_cfg[0] = 32'h100; lat_cfg[0] = 2; rdata_cfg[0] = 32'hDEADBEEF;
    r = cyc + 1;
    i_goal[0] = acks_i[0] + 1;
    txn(0, r + 1, r + 3, K_IACK, 32'hDEADBEEF, 32'h100, 1'b0, 4'hF, 32'h55);
    wait_to(r + 7);

    // Two back-to-back stores: one transaction every three cycles.
    d_addr_cfg[0] = 32'h2004; d_wr_cfg[0] = 1'b1; d_mask_cfg[0] = 4'h3;
    d_wd_cfg[0] = 32'h1234; lat_cfg[0] = 1; rdata_cfg[0] = 32'hCAFE0001;
    r = cyc + 1;
    d_goal[0] = acks_d[0] + 2;
    txn(0, r + 1, r + 2, K_DACK, 32'hCAFE0001, 32'h2004, 1'b1, 4'h3, 32'h1234);
    txn(0, r + 4, r + 5, K_DACK, 32'hCAFE0001, 32'h2004, 1'b1, 4'h3, 32'h1234);
    wait_to(r + 9);

    // Watchdog expiry: mem_req high four cycles, error in the fourth.
    i_addr_cfg[0] = 32'h500; lat_cfg[0] = -1;
    r = cyc + 1;
    i_goal[0] = acks_i[0] + 1;
    txn(0, r + 1, r + 4, K_IERR, 32'h0, 32'h500, 1'b0, 4'hF, 32'h1234);
    wait_to(r + 8);

    // Ack in the expiry cycle wins over the error.
    i_addr_cfg[0] = 32'h504; lat_cfg[0] = 3; rdata_cfg[0] = 32'h600DF00D;
    r = cyc + 1;
    i_goal[0] = acks_i[0] + 1;
    txn(0, r + 1, r + 4, K_IACK, 32'h600DF00D, 32'h504, 1'b0, 4'hF, 32'h1234);
    wait_to(r + 8);

    // Reset while a store is in flight, then a spurious ack in IDLE.
    d_addr_cfg[1] = 32'h600; d_wr_cfg[1] = 1'b1; d_mask_cfg[1] = 4'hC;
    d_wd_cfg[1] = 32'hA5A5A5A5; lat_cfg[1] = -1; rdata_cfg[1] = 32'h11111111;
    r = cyc + 1;
    d_goal[1] = acks_d[1] + 1;
    ev(1, K_GRANT, r + 1, 32'h600, 1'b1, 4'hC, 32'hA5A5A5A5);
    ev(1, K_DROP,  r + 3, 32'h0, 1'b0, 4'h0, 32'h0);
    ev(1, K_SNAP,  r + 5, 32'h0, 1'b0, 4'h0, 32'h0);
    ev(1, K_SNAP,  r + 6, 32'h0, 1'b0, 4'h0, 32'h0);
    wait_to(r + 1);
    rst_cfg[1] = 1'b0; d_goal[1] = acks_d[1];
    wait_to(r + 2);
    rst_cfg[1] = 1'b1;
    wait_to(r + 4);
    spur_cfg[1] = 1'b1;
    wait_to(r + 5);
    spur_cfg[1] = 1'b0;
    wait_to(r + 9);
    fin = 1'b1;
  end

endmodule
